// File: rtl/cnt_dn_ld_pkg.sv
// Shared definitions for the loadable down-counter: state encoding and
// default parameter values.
package cnt_dn_ld_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int WIDTH_DEF  = 4;
   localparam int TMR_DEF    = 0;
   localparam int RELOAD_DEF = 0;

endpackage

// File: rtl/vote.sv
// Bitwise 2-of-3 majority voter used to scrub triplicated register sets.
module vote #(
   parameter int Width = 1
) (
   input  logic [Width-1:0] i_a,
   input  logic [Width-1:0] i_b,
   input  logic [Width-1:0] i_c,
   output logic [Width-1:0] o_y
);

   assign o_y = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/cnt_dn_ld.sv
// Loadable down-counter / terminal-count timer with one-shot or periodic
// expiry and optional triplicated, self-scrubbing state.
module cnt_dn_ld
   import cnt_dn_ld_pkg::*;
#(
   parameter int Width  = WIDTH_DEF,
   parameter int TMR    = TMR_DEF,
   parameter int RELOAD = RELOAD_DEF
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             LD,
   input  logic [Width-1:0] D,
   input  logic             CE,
   output logic [Width-1:0] Q,
   output logic             BUSY,
   output logic             TC
);

   localparam logic [Width-1:0] ONE = Width'(1);

   logic [Width-1:0] w_cnt;
   logic [Width-1:0] w_rld;
   state_t           w_st;
   logic             w_tc;

   logic [Width-1:0] w_cnt_nxt;
   logic [Width-1:0] w_rld_nxt;
   state_t           w_st_nxt;
   logic             w_tc_nxt;

   // Next-state logic sees only the (voted) current values, so every copy
   // is rewritten with the same value each cycle.
   always_comb begin
      w_cnt_nxt = w_cnt;
      w_rld_nxt = w_rld;
      w_st_nxt  = w_st;
      w_tc_nxt  = 1'b0;
      if (LD) begin
         w_cnt_nxt = D;
         w_rld_nxt = D;
         w_st_nxt  = (D != '0) ? RUN : IDLE;
      end else if ((w_st == RUN) && CE) begin
         if (w_cnt == ONE) begin
            w_tc_nxt = 1'b1;
            if (RELOAD != 0) begin
               w_cnt_nxt = w_rld;
            end else begin
               w_cnt_nxt = '0;
               w_st_nxt  = IDLE;
            end
         end else begin
            w_cnt_nxt = w_cnt - ONE;
         end
      end
   end

   generate
      if (TMR != 0) begin : g_tmr
         logic [Width-1:0] r_cnt0, r_cnt1, r_cnt2;
         logic [Width-1:0] r_rld0, r_rld1, r_rld2;
         state_t           r_st0,  r_st1,  r_st2;
         logic             r_tc0,  r_tc1,  r_tc2;
         logic [1:0]       w_sttc;

         always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
               r_cnt0 <= '0;
               r_cnt1 <= '0;
               r_cnt2 <= '0;
               r_rld0 <= '0;
               r_rld1 <= '0;
               r_rld2 <= '0;
               r_st0  <= IDLE;
               r_st1  <= IDLE;
               r_st2  <= IDLE;
               r_tc0  <= 1'b0;
               r_tc1  <= 1'b0;
               r_tc2  <= 1'b0;
            end else begin
               r_cnt0 <= w_cnt_nxt;
               r_cnt1 <= w_cnt_nxt;
               r_cnt2 <= w_cnt_nxt;
               r_rld0 <= w_rld_nxt;
               r_rld1 <= w_rld_nxt;
               r_rld2 <= w_rld_nxt;
               r_st0  <= w_st_nxt;
               r_st1  <= w_st_nxt;
               r_st2  <= w_st_nxt;
               r_tc0  <= w_tc_nxt;
               r_tc1  <= w_tc_nxt;
               r_tc2  <= w_tc_nxt;
            end
         end

         vote #(.Width(Width)) u_vote_cnt (
            .i_a (r_cnt0),
            .i_b (r_cnt1),
            .i_c (r_cnt2),
            .o_y (w_cnt)
         );

         vote #(.Width(Width)) u_vote_rld (
            .i_a (r_rld0),
            .i_b (r_rld1),
            .i_c (r_rld2),
            .o_y (w_rld)
         );

         // State and TC travel together as one 2-bit voted word.
         vote #(.Width(2)) u_vote_sttc (
            .i_a ({r_st0, r_tc0}),
            .i_b ({r_st1, r_tc1}),
            .i_c ({r_st2, r_tc2}),
            .o_y (w_sttc)
         );

         assign w_st = state_t'(w_sttc[1]);
         assign w_tc = w_sttc[0];
      end else begin : g_single
         logic [Width-1:0] r_cnt;
         logic [Width-1:0] r_rld;
         state_t           r_st;
         logic             r_tc;

         always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
               r_cnt <= '0;
               r_rld <= '0;
               r_st  <= IDLE;
               r_tc  <= 1'b0;
            end else begin
               r_cnt <= w_cnt_nxt;
               r_rld <= w_rld_nxt;
               r_st  <= w_st_nxt;
               r_tc  <= w_tc_nxt;
            end
         end

         assign w_cnt = r_cnt;
         assign w_rld = r_rld;
         assign w_st  = r_st;
         assign w_tc  = r_tc;
      end
   endgenerate

   assign Q    = w_cnt;
   assign BUSY = (w_st == RUN);
   assign TC   = w_tc;

endmodule

// File: tb/tb_cnt_dn_ld.sv
// Directed bench: one-shot, periodic and TMR one-shot counters share stimulus.
module tb_cnt_dn_ld;
   import cnt_dn_ld_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ld;
   logic       ce;
   logic [3:0] d;

   logic [3:0] q_os, q_pr, q_tm;
   logic       b_os, b_pr, b_tm;
   logic       t_os, t_pr, t_tm;

   int ntests = 0;
   int nfail  = 0;

   always #5 clk = ~clk;

   cnt_dn_ld #(.Width(4), .TMR(0), .RELOAD(0)) u_os (
      .CLK(clk), .RST_N(rst_n), .LD(ld), .D(d), .CE(ce),
      .Q(q_os), .BUSY(b_os), .TC(t_os)
   );

   cnt_dn_ld #(.Width(4), .TMR(0), .RELOAD(1)) u_pr (
      .CLK(clk), .RST_N(rst_n), .LD(ld), .D(d), .CE(ce),
      .Q(q_pr), .BUSY(b_pr), .TC(t_pr)
   );

   cnt_dn_ld #(.Width(4), .TMR(1), .RELOAD(0)) u_tm (
      .CLK(clk), .RST_N(rst_n), .LD(ld), .D(d), .CE(ce),
      .Q(q_tm), .BUSY(b_tm), .TC(t_tm)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp)
      else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-shot expectation applies to both u_os and u_tm; periodic to u_pr.
   task automatic chk_all(input string tag, input int eq, input bit eb, input bit et,
                          input int pq, input bit pb, input bit pt);
      chk({tag, ".os.q"},  32'(q_os), eq);
      chk({tag, ".os.bs"}, 32'(b_os), 32'(eb));
      chk({tag, ".os.tc"}, 32'(t_os), 32'(et));
      chk({tag, ".tm.q"},  32'(q_tm), eq);
      chk({tag, ".tm.bs"}, 32'(b_tm), 32'(eb));
      chk({tag, ".tm.tc"}, 32'(t_tm), 32'(et));
      chk({tag, ".pr.q"},  32'(q_pr), pq);
      chk({tag, ".pr.bs"}, 32'(b_pr), 32'(pb));
      chk({tag, ".pr.tc"}, 32'(t_pr), 32'(pt));
   endtask

   int per_os_q [6] = '{1, 0, 0, 0, 0, 0};
   bit per_os_b [6] = '{1, 0, 0, 0, 0, 0};
   bit per_os_t [6] = '{0, 1, 0, 0, 0, 0};
   int per_pr_q [6] = '{1, 2, 1, 2, 1, 2};
   bit per_pr_t [6] = '{0, 1, 0, 1, 0, 1};

   bit gap_ce   [7] = '{1, 0, 0, 1, 1, 0, 1};
   int gap_os_q [7] = '{3, 3, 3, 2, 1, 1, 0};
   int gap_pr_q [7] = '{3, 3, 3, 2, 1, 1, 4};

   initial begin
      rst_n = 1'b0;
      ld    = 1'b0;
      ce    = 1'b0;
      d     = 4'd7;

      // Reset held with LD/CE toggling
      for (int i = 0; i < 3; i++) begin
         ld = (i % 2) == 0;
         ce = (i % 2) != 0;
         tick();
         chk_all("rst", 0, 0, 0, 0, 0, 0);
      end

      rst_n = 1'b1;
      ld = 1'b1; d = 4'd5; ce = 1'b0;
      tick();
      chk_all("ld5", 5, 1, 0, 5, 1, 0);

      // One-shot from 3
      d = 4'd3;
      tick();
      chk_all("os.ld3", 3, 1, 0, 3, 1, 0);
      ld = 1'b0; ce = 1'b1;
      tick();
      chk_all("os.c1", 2, 1, 0, 2, 1, 0);
      tick();
      chk_all("os.c2", 1, 1, 0, 1, 1, 0);
      tick();
      chk_all("os.c3", 0, 0, 1, 3, 1, 1);
      tick();
      chk_all("os.c4", 0, 0, 0, 2, 1, 0);

      // Periodic from 2
      ce = 1'b0; ld = 1'b1; d = 4'd2;
      tick();
      chk_all("per.ld2", 2, 1, 0, 2, 1, 0);
      ld = 1'b0; ce = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk_all($sformatf("per.c%0d", i), per_os_q[i], per_os_b[i], per_os_t[i],
                 per_pr_q[i], 1'b1, per_pr_t[i]);
      end

      // LD beats expiry
      ce = 1'b0; ld = 1'b1; d = 4'd3;
      tick();
      chk_all("pri.ld3", 3, 1, 0, 3, 1, 0);
      ld = 1'b0; ce = 1'b1;
      tick();
      tick();
      chk_all("pri.q1", 1, 1, 0, 1, 1, 0);
      ld = 1'b1; d = 4'd9;
      tick();
      chk_all("pri.ld9", 9, 1, 0, 9, 1, 0);
      d = 4'd0;
      tick();
      chk_all("pri.ld0", 0, 0, 0, 0, 0, 0);
      ld = 1'b0;
      tick();
      chk_all("pri.idle", 0, 0, 0, 0, 0, 0);

      // Full-range load
      ce = 1'b0; ld = 1'b1; d = 4'd15;
      tick();
      chk_all("full.ld", 15, 1, 0, 15, 1, 0);
      ld = 1'b0; ce = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         tick();
         if (i < 15)
            chk_all($sformatf("full.c%0d", i), 15 - i, 1, 0, 15 - i, 1, 0);
         else
            chk_all("full.exp", 0, 0, 1, 15, 1, 1);
      end

      // CE gaps stretch the interval
      ce = 1'b0; ld = 1'b1; d = 4'd4;
      tick();
      chk_all("gap.ld4", 4, 1, 0, 4, 1, 0);
      ld = 1'b0;
      for (int i = 0; i < 7; i++) begin
         ce = gap_ce[i];
         tick();
         chk_all($sformatf("gap.c%0d", i), gap_os_q[i], (i < 6), (i == 6),
                 gap_pr_q[i], 1'b1, (i == 6));
      end

      // Single-copy upsets in the TMR instance
      ce = 1'b0; ld = 1'b1; d = 4'd8;
      tick();
      chk_all("tmr.ld8", 8, 1, 0, 8, 1, 0);
      ld = 1'b0;
      force u_tm.g_tmr.r_cnt1 = 4'h3;
      #1;
      chk("tmr.upc.q",  32'(q_tm), 8);
      chk("tmr.upc.bs", 32'(b_tm), 1);
      chk("tmr.upc.tc", 32'(t_tm), 0);
      release u_tm.g_tmr.r_cnt1;
      tick();
      chk("tmr.scrub.c0", 32'(u_tm.g_tmr.r_cnt0), 8);
      chk("tmr.scrub.c1", 32'(u_tm.g_tmr.r_cnt1), 8);
      chk("tmr.scrub.c2", 32'(u_tm.g_tmr.r_cnt2), 8);
      chk("tmr.scrub.q",  32'(q_tm), 8);
      force u_tm.g_tmr.r_st2 = IDLE;
      #1;
      chk("tmr.ups.bs", 32'(b_tm), 1);
      chk("tmr.ups.q",  32'(q_tm), 8);
      chk("tmr.ups.tc", 32'(t_tm), 0);
      release u_tm.g_tmr.r_st2;
      tick();
      chk("tmr.scrub.st2", 32'(logic'(u_tm.g_tmr.r_st2)), 32'(logic'(RUN)));
      chk("tmr.scrub.bs",  32'(b_tm), 1);
      ce = 1'b1;
      tick();
      chk_all("tmr.dec", 7, 1, 0, 7, 1, 0);

      // Asynchronous reset mid-count
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk_all("arst", 0, 0, 0, 0, 0, 0);
      #1;
      rst_n = 1'b1;
      tick();
      chk_all("arst.hold", 0, 0, 0, 0, 0, 0);
      ld = 1'b1; d = 4'd2;
      tick();
      chk_all("arst.ld2", 2, 1, 0, 2, 1, 0);
      ld = 1'b0; ce = 1'b0;

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
